// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Pushbutton reset synchroniser and staged reset-release
//               sequencer. Every channel is cleared asynchronously by RST_n.
//               After a synchronised release and a minimum stretch, channels
//               are released one at a time, from bit 0 upwards, on negedge clk.
//               Optional feature macro RST_SEQ_SWRST_EN adds the sw_rst_req
//               input, which restarts the sequence from the stretch phase.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_OUT        = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 4
) (
    input  logic               clk,
    input  logic               RST_n,
`ifdef RST_SEQ_SWRST_EN
    input  logic               sw_rst_req,
`endif
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               seq_done
);

    // The counter only ever reaches max(STRETCH_CYCLES, STAGE_GAP)-1.
    localparam int c_MAX_COUNT = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int c_CW        = (c_MAX_COUNT > 1) ? $clog2(c_MAX_COUNT) : 1;
    localparam logic [c_CW-1:0] c_STRETCH_LAST = c_CW'(STRETCH_CYCLES - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST     = c_CW'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [NUM_OUT-1:0]     r_out;
    logic                   r_done;

    state_t                 w_state_next;
    logic [c_CW-1:0]        w_cnt_next;
    logic [NUM_OUT-1:0]     w_out_next;
    logic                   w_done_next;
    logic [NUM_OUT-1:0]     w_out_shift;
    logic                   w_sync_due;

    // Thermometer step: releases the next channel above those already high.
    assign w_out_shift = (r_out << 1) | NUM_OUT'(1);

    // HOLD leaves on the edge at which sync_rst_n (last stage) turns high,
    // i.e. when the stage feeding it is already high.
    assign w_sync_due = r_sync[SYNC_STAGES-2] | r_sync[SYNC_STAGES-1];

    // Synchroniser chain: async clear, releases by shifting in ones.
    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer state and output flops; outputs come straight from here.
    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_out   <= w_out_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_out_next   = r_out;
        w_done_next  = r_done;
        case (r_state)
            S_HOLD: begin
                w_cnt_next  = '0;
                w_out_next  = '0;
                w_done_next = 1'b0;
                if (w_sync_due) begin
                    w_state_next = S_STRETCH;
                end
            end
            S_STRETCH: begin
                if (r_cnt == c_STRETCH_LAST) begin
                    w_cnt_next   = '0;
                    w_out_next   = w_out_shift;
                    w_done_next  = w_out_shift[NUM_OUT-1];
                    w_state_next = w_out_shift[NUM_OUT-1] ? S_DONE : S_RELEASE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_out_next   = w_out_shift;
                    w_done_next  = w_out_shift[NUM_OUT-1];
                    w_state_next = w_out_shift[NUM_OUT-1] ? S_DONE : S_RELEASE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_HOLD;
                w_cnt_next   = '0;
                w_out_next   = '0;
                w_done_next  = 1'b0;
            end
        endcase
`ifdef RST_SEQ_SWRST_EN
        // Software request restarts from a fresh stretch; HOLD ignores it.
        if (sw_rst_req && (r_state != S_HOLD)) begin
            w_state_next = S_STRETCH;
            w_cnt_next   = '0;
            w_out_next   = '0;
            w_done_next  = 1'b0;
        end
`endif
    end

    assign rst_n_out = r_out;
    assign seq_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer. Two instances share
//               clk/RST_n: (2,3,4,2) and (2,1,1,1). Expected outputs come from
//               an arithmetic model: channel k is high once the edge index
//               since release reaches base+STRETCH_CYCLES+k*STAGE_GAP, where
//               base is SYNC_STAGES-1 or the last accepted software request.
//               Build with RST_SEQ_SWRST_EN to exercise sw_rst_req as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int SS  = 2;
    localparam int NO  = 3;
    localparam int ST  = 4;
    localparam int GP  = 2;
    localparam int NO1 = 1;
    localparam int ST1 = 1;
    localparam int GP1 = 1;

    logic          clk    = 1'b1;
    logic          clk_en = 1'b0;
    logic          RST_n  = 1'b0;
    logic          sw     = 1'b0;
    logic [NO-1:0] out0;
    logic          done0;
    logic [NO1-1:0] out1;
    logic          done1;

    int checks = 0;
    int errors = 0;
    int t      = -1;      // index of the latest negedge since RST_n release
    int base   = SS - 1;  // reference edge the stretch is counted from

    always #5 clk = clk_en ? ~clk : 1'b1;

    reset_sequencer #(
        .SYNC_STAGES(SS), .NUM_OUT(NO), .STRETCH_CYCLES(ST), .STAGE_GAP(GP)
    ) dut (
        .clk       (clk),
        .RST_n     (RST_n),
`ifdef RST_SEQ_SWRST_EN
        .sw_rst_req(sw),
`endif
        .rst_n_out (out0),
        .seq_done  (done0)
    );

    reset_sequencer #(
        .SYNC_STAGES(SS), .NUM_OUT(NO1), .STRETCH_CYCLES(ST1), .STAGE_GAP(GP1)
    ) dut1 (
        .clk       (clk),
        .RST_n     (RST_n),
`ifdef RST_SEQ_SWRST_EN
        .sw_rst_req(sw),
`endif
        .rst_n_out (out1),
        .seq_done  (done1)
    );

    function automatic logic [7:0] exp_vec(input int tt, input int bb, input int n,
                                           input int str, input int gap);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            if (tt >= bb + str + k * gap) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] e0;
        logic [7:0] e1;
        e0 = exp_vec(t, base, NO, ST, GP);
        e1 = exp_vec(t, base, NO1, ST1, GP1);
        checks++;
        assert (out0 === e0[NO-1:0]) else begin
            errors++;
            $error("FAIL %s out0 t=%0d got %b exp %b", tag, t, out0, e0[NO-1:0]);
        end
        checks++;
        assert (done0 === e0[NO-1]) else begin
            errors++;
            $error("FAIL %s done0 t=%0d got %b exp %b", tag, t, done0, e0[NO-1]);
        end
        checks++;
        assert (out1 === e1[0:0]) else begin
            errors++;
            $error("FAIL %s out1 t=%0d got %b exp %b", tag, t, out1, e1[0:0]);
        end
        checks++;
        assert (done1 === e1[0]) else begin
            errors++;
            $error("FAIL %s done1 t=%0d got %b exp %b", tag, t, done1, e1[0]);
        end
    endtask

    // One negedge; model advances only while RST_n is released.
    task automatic edge_step(input string tag);
        @(negedge clk);
        if (RST_n) begin
            t++;
`ifdef RST_SEQ_SWRST_EN
            if (sw && t >= SS) base = t;
`endif
        end
        #1 check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) edge_step(tag);
    endtask

    // Called 1 ns after a negedge: short low pulse, released well before next negedge.
    task automatic pulse_rst(input int low_ns);
        #1;
        RST_n = 1'b0;
        t     = -1;
        base  = SS - 1;
        #1 check_all("rst_pulse");
        #(low_ns - 1) RST_n = 1'b1;
    endtask

    initial begin
        clk_en = 1'b1;
        #2 check_all("reset_init");
        run(2, "reset_held");
        #3 RST_n = 1'b1;

        // Nominal release: channels at edges 5/7/9, dut1 at 2.
        run(12, "nominal");

        // Reset glitch between edges 6 and 7 of a fresh sequence.
        pulse_rst(3);
        run(7, "pre_glitch");
        pulse_rst(3);
        run(12, "post_glitch");

        // Release while the clock is stopped, then restart the clock.
        #1 RST_n = 1'b0;
        t    = -1;
        base = SS - 1;
        clk_en = 1'b0;
        #20 RST_n = 1'b1;
        #10 check_all("no_clock");
        clk_en = 1'b1;
        run(12, "clock_restart");

`ifdef RST_SEQ_SWRST_EN
        // Single-edge software request on edge 12.
        pulse_rst(3);
        run(12, "sw_pre");
        sw = 1'b1;
        edge_step("sw_edge12");
        sw = 1'b0;
        run(10, "sw_after12");

        // Request held across edges 3..9: releases at 13/15/17.
        pulse_rst(3);
        run(3, "swh_pre");
        sw = 1'b1;
        run(7, "swh_held");
        sw = 1'b0;
        run(10, "swh_after");
`endif

        // Randomised reset pulses, run lengths and software requests.
        for (int s = 0; s < 12; s++) begin
            pulse_rst(int'($urandom_range(2, 7)));
            for (int i = 0; i < int'($urandom_range(3, 25)); i++) begin
`ifdef RST_SEQ_SWRST_EN
                sw = ($urandom_range(0, 7) == 0);
`endif
                edge_step("random");
            end
            sw = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
